// File: rtl/stage_fetch_pkg.sv
// rtl/stage_fetch_pkg.sv - shared types and defaults for the fetch stage
package stage_fetch_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_STEP_DEFAULT      = 32'd4;
    localparam word_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // One instruction as presented to decode
    typedef struct packed {
        word_t pc;
        word_t ir;
        word_t pc_next;
    } fetch_entry_t;

    // Redirect targets are always word aligned
    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/stage_fetch_buffer.sv
// rtl/stage_fetch_buffer.sv - two-entry in-order output register plus skid
module stage_fetch_buffer
    import stage_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic         out_valid_o,
    output fetch_entry_t out_data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic         r_out_valid;
    logic         r_skid_valid;
    fetch_entry_t r_out;
    fetch_entry_t r_skid;
    logic         w_out_free;

    // The output slot can take a new entry when empty or being consumed
    assign w_out_free = !r_out_valid || pop_i;

    // Skid always refills the output before a newer word so order is kept
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= push_i;
                if (push_i) begin
                    r_skid <= push_data_i;
                end
            end else begin
                r_out_valid <= push_i;
                if (push_i) begin
                    r_out <= push_data_i;
                end
            end
        end else if (push_i) begin
            r_skid       <= push_data_i;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out;
    // The skid is only ever occupied behind a valid output entry
    assign full_o      = r_out_valid && r_skid_valid;
    assign empty_o     = !r_out_valid;

endmodule

// File: rtl/stage_fetch.sv
// rtl/stage_fetch.sv - instruction fetch stage with credit-based issue
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter word_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter word_t PC_STEP      = PC_STEP_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        halt_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_ir_o,
    output logic [31:0] fetch_pc_next_o,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i
);

    word_t        r_pc;
    word_t        r_inflight_pc;
    logic         r_inflight;
    logic         r_inflight_epoch;
    logic         r_epoch;

    logic         w_out_valid;
    fetch_entry_t w_out_data;
    logic         w_buf_full;
    logic         w_buf_empty;
    logic         w_transfer;
    logic [1:0]   w_occupancy;
    logic [1:0]   w_credits;
    logic         w_issue;
    logic         w_push;
    fetch_entry_t w_push_data;

    assign w_transfer  = w_out_valid && fetch_ready_i;

    // Every buffered or outstanding word holds one of the two credits
    assign w_occupancy = {1'b0, !w_buf_empty} + {1'b0, w_buf_full} + {1'b0, r_inflight};
    assign w_credits   = 2'd2 - w_occupancy;

    // A transfer this cycle frees a slot, so issue may reuse it at once
    assign w_issue     = reset_ni && !halt_i && !jmp_valid_i &&
                         ((w_credits != 2'd0) || w_transfer);

    // Responses issued under an older epoch are stale and dropped
    assign w_push      = r_inflight && (r_inflight_epoch == r_epoch);

    assign w_push_data.pc      = r_inflight_pc;
    assign w_push_data.ir      = imem_data_i;
    assign w_push_data.pc_next = r_inflight_pc + PC_STEP;

    // Program counter, epoch and the single outstanding-read tracker
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pc             <= RESET_VECTOR;
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_inflight_pc    <= RESET_VECTOR;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc    <= r_pc;
                r_inflight_epoch <= r_epoch;
            end
            if (jmp_valid_i) begin
                r_pc    <= align_word(jmp_addr_i);
                r_epoch <= ~r_epoch;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    stage_fetch_buffer u_buffer (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .flush_i     (jmp_valid_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (fetch_ready_i),
        .out_valid_o (w_out_valid),
        .out_data_o  (w_out_data),
        .full_o      (w_buf_full),
        .empty_o     (w_buf_empty)
    );

    assign imem_req_o      = w_issue;
    assign imem_addr_o     = r_pc;
    assign fetch_valid_o   = w_out_valid;
    assign fetch_pc_o      = w_out_data.pc;
    assign fetch_ir_o      = w_out_data.ir;
    assign fetch_pc_next_o = w_out_data.pc_next;

endmodule

// File: tb/tb_stage_fetch.sv
// tb/tb_stage_fetch.sv - directed table-driven bench for stage_fetch
module tb_stage_fetch;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        halt_i = 1'b0;
    logic        jmp_valid_i = 1'b0;
    logic [31:0] jmp_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_ir_o;
    logic [31:0] fetch_pc_next_o;
    logic        fetch_valid_o;
    logic        fetch_ready_i = 1'b0;
    logic [31:0] r_mem_q = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ready;
        logic        halt;
        logic        jv;
        logic [31:0] ja;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    stage_fetch dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .halt_i          (halt_i),
        .jmp_valid_i     (jmp_valid_i),
        .jmp_addr_i      (jmp_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .fetch_pc_o      (fetch_pc_o),
        .fetch_ir_o      (fetch_ir_o),
        .fetch_pc_next_o (fetch_pc_next_o),
        .fetch_valid_o   (fetch_valid_o),
        .fetch_ready_i   (fetch_ready_i)
    );

    always #5 clk = ~clk;

    // Synchronous memory whose word at each address is the address itself
    always @(posedge clk) begin
        if (imem_req_o) r_mem_q <= imem_addr_o;
    end
    assign imem_data_i = r_mem_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rdy, input logic hlt, input logic jv,
                                input logic [31:0] ja, input logic req,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] pc);
        vec_t e;
        e.ready = rdy; e.halt = hlt; e.jv = jv; e.ja = ja;
        e.exp_req = req; e.exp_addr = addr; e.exp_valid = v; e.exp_pc = pc;
        vecs.push_back(e);
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " req"},     {31'd0, imem_req_o},    32'd0);
        check({tag, " addr"},    imem_addr_o,            32'd0);
        check({tag, " valid"},   {31'd0, fetch_valid_o}, 32'd0);
        check({tag, " pc"},      fetch_pc_o,             32'd0);
        check({tag, " ir"},      fetch_ir_o,             32'd0);
        check({tag, " pc_next"}, fetch_pc_next_o,        32'd0);
    endtask

    initial begin
        //   rdy hlt jv  ja             req addr           v  pc
        add(1, 0, 0, 0,             1, 32'h0,          0, 0);
        add(1, 0, 0, 0,             1, 32'h4,          0, 0);
        add(1, 0, 0, 0,             1, 32'h8,          1, 32'h0);
        add(1, 0, 0, 0,             1, 32'hC,          1, 32'h4);
        add(1, 0, 0, 0,             1, 32'h10,         1, 32'h8);
        add(1, 0, 0, 0,             1, 32'h14,         1, 32'hC);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0,         0, 32'h18,         1, 32'h10);
        add(1, 0, 0, 0,             1, 32'h18,         1, 32'h10);
        add(1, 0, 0, 0,             1, 32'h1C,         1, 32'h14);
        add(1, 0, 0, 0,             1, 32'h20,         1, 32'h18);
        add(0, 0, 0, 0,             0, 32'h24,         1, 32'h1C);
        add(0, 0, 1, 32'h103,       0, 32'h24,         1, 32'h1C);
        add(1, 0, 0, 0,             1, 32'h100,        0, 0);
        add(1, 0, 0, 0,             1, 32'h104,        0, 0);
        add(1, 0, 0, 0,             1, 32'h108,        1, 32'h100);
        add(1, 0, 1, 32'h20,        0, 32'h10C,        1, 32'h104);
        add(1, 0, 0, 0,             1, 32'h20,         0, 0);
        add(1, 0, 0, 0,             1, 32'h24,         0, 0);
        add(1, 0, 1, 32'h200,       0, 32'h28,         1, 32'h20);
        add(1, 0, 0, 0,             1, 32'h200,        0, 0);
        add(1, 0, 0, 0,             1, 32'h204,        0, 0);
        add(1, 0, 1, 32'h300,       0, 32'h208,        1, 32'h200);
        add(1, 0, 1, 32'h404,       0, 32'h300,        0, 0);
        add(1, 0, 0, 0,             1, 32'h404,        0, 0);
        add(1, 0, 0, 0,             1, 32'h408,        0, 0);
        add(1, 0, 0, 0,             1, 32'h40C,        1, 32'h404);
        add(1, 1, 1, 32'hFFFF_FFFA, 0, 32'h410,        1, 32'h408);
        add(1, 1, 0, 0,             0, 32'hFFFF_FFF8,  0, 0);
        add(1, 0, 0, 0,             1, 32'hFFFF_FFF8,  0, 0);
        add(1, 0, 0, 0,             1, 32'hFFFF_FFFC,  0, 0);
        add(1, 0, 0, 0,             1, 32'h0,          1, 32'hFFFF_FFF8);
        add(1, 0, 0, 0,             1, 32'h4,          1, 32'hFFFF_FFFC);
        add(1, 0, 0, 0,             1, 32'h8,          1, 32'h0);
        add(0, 1, 0, 0,             0, 32'hC,          1, 32'h4);
        add(1, 1, 0, 0,             0, 32'hC,          1, 32'h4);
        add(1, 1, 0, 0,             0, 32'hC,          1, 32'h8);
        add(1, 1, 0, 0,             0, 32'hC,          0, 0);
        add(1, 1, 0, 0,             0, 32'hC,          0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #2 reset_ni = 1'b1;

        for (int c = 0; c < vecs.size(); c++) begin
            @(negedge clk);
            fetch_ready_i = vecs[c].ready;
            halt_i        = vecs[c].halt;
            jmp_valid_i   = vecs[c].jv;
            jmp_addr_i    = vecs[c].ja;
            #1;
            check($sformatf("c%0d req", c),   {31'd0, imem_req_o},    {31'd0, vecs[c].exp_req});
            check($sformatf("c%0d addr", c),  imem_addr_o,            vecs[c].exp_addr);
            check($sformatf("c%0d valid", c), {31'd0, fetch_valid_o}, {31'd0, vecs[c].exp_valid});
            if (vecs[c].exp_valid) begin
                check($sformatf("c%0d pc", c),      fetch_pc_o,      vecs[c].exp_pc);
                check($sformatf("c%0d ir", c),      fetch_ir_o,      vecs[c].exp_pc);
                check($sformatf("c%0d pc_next", c), fetch_pc_next_o, vecs[c].exp_pc + 32'd4);
            end
        end

        // Run a few more cycles, then reset asynchronously mid-cycle
        @(negedge clk);
        halt_i = 1'b0; jmp_valid_i = 1'b0; fetch_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        #2 reset_ni = 1'b0;
        #1;
        check_reset_state("async");
        repeat (2) @(posedge clk);
        #2 reset_ni = 1'b1;

        // The memory still holds a pre-reset word; it must not be presented
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst c%0d req", k),  {31'd0, imem_req_o}, 32'd1);
            check($sformatf("rst c%0d addr", k), imem_addr_o, 32'(k * 4));
            check($sformatf("rst c%0d valid", k), {31'd0, fetch_valid_o}, (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                check($sformatf("rst c%0d pc", k), fetch_pc_o, 32'((k - 2) * 4));
                check($sformatf("rst c%0d ir", k), fetch_ir_o, 32'((k - 2) * 4));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
